// File: rtl/radix_reduction_tree.sv
// N-to-1 flit concentrator built as a tree of RADIX:1 round-robin nodes, each with a 2-entry output buffer.
// Define PKT_LOCK_EN to lock each node onto a multi-flit packet (HEAD=1,TAIL=0 .. TAIL=1) so packets leave contiguous.

module radix_reduction_node #(
  parameter int RADIX    = 3,
  parameter int FLIT_W   = 32,
  parameter int HEAD_BIT = FLIT_W - 1,
  parameter int TAIL_BIT = FLIT_W - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RADIX*FLIT_W-1:0] in_data,
  input  logic [RADIX-1:0]        in_valid,
  output logic [RADIX-1:0]        in_avail,
  output logic [FLIT_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_avail
);
  localparam int PW = $clog2(RADIX);

  logic [PW-1:0]     ptr_q, ptr_d, gnt;
  logic              gnt_any, push, pop;
  logic [1:0]        cnt_q, cnt_d;
  logic              rp_q, wp_q;
  logic [FLIT_W-1:0] mem_q [2];
  logic [FLIT_W-1:0] gnt_data;

`ifdef PKT_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_e;
  lock_e         lock_q, lock_d;
  logic [PW-1:0] lidx_q, lidx_d;
`endif

  always_comb begin : arb
    int unsigned idx;
    gnt_any = 1'b0;
    gnt     = '0;
    idx     = 0;
`ifdef PKT_LOCK_EN
    if (lock_q == LOCKED) begin
      gnt     = lidx_q;
      gnt_any = in_valid[lidx_q];
    end else
`endif
    for (int unsigned k = 0; k < RADIX; k++) begin
      idx = (ptr_q + k) % RADIX;
      if (!gnt_any && in_valid[idx]) begin
        gnt_any = 1'b1;
        gnt     = PW'(idx);
      end
    end
  end

  // Avail depends only on local count and grant, never on out_avail.
  assign gnt_data  = in_data[gnt*FLIT_W +: FLIT_W];
  assign push      = rst && gnt_any && (cnt_q != 2'd2);
  assign out_valid = rst && (cnt_q != 2'd0);
  assign pop       = out_valid && out_avail;
  assign out_data  = out_valid ? mem_q[rp_q] : '0;

  always_comb begin
    in_avail = '0;
    if (push) in_avail[gnt] = 1'b1;
  end

  // ptr <= g+1 on every transfer; while locked g == ptr-1 already, so ptr effectively holds.
  always_comb begin
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (push) ptr_d = (gnt == PW'(RADIX - 1)) ? '0 : gnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      ptr_q <= '0;
      rp_q  <= 1'b0;
      wp_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      if (push) wp_q <= ~wp_q;
      if (pop)  rp_q <= ~rp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= gnt_data;
  end

`ifdef PKT_LOCK_EN
  always_comb begin
    lock_d = lock_q;
    lidx_d = lidx_q;
    if (push) begin
      case (lock_q)
        UNLOCKED: if (gnt_data[HEAD_BIT] && !gnt_data[TAIL_BIT]) begin
          lock_d = LOCKED;
          lidx_d = gnt;
        end
        LOCKED:   if (gnt_data[TAIL_BIT]) lock_d = UNLOCKED;
        default:  lock_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_q <= UNLOCKED;
      lidx_q <= '0;
    end else begin
      lock_q <= lock_d;
      lidx_q <= lidx_d;
    end
  end
`endif
endmodule

module radix_reduction_tree #(
  parameter int FAN_IN   = 54,
  parameter int RADIX    = 3,
  parameter int FLIT_W   = 32,
  parameter int HEAD_BIT = FLIT_W - 1,
  parameter int TAIL_BIT = FLIT_W - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W*FAN_IN-1:0] in,
  input  logic [FAN_IN-1:0]        in_valid,
  output logic [FAN_IN-1:0]        in_avail,
  output logic [FLIT_W-1:0]        out,
  output logic                     out_valid,
  input  logic                     out_avail
);
  function automatic int calc_levels(int fan, int rad);
    int     l = 0;
    longint p = 1;
    while (p < fan) begin
      p = p * rad;
      l++;
    end
    return l;
  endfunction

  function automatic int ipow(int b, int unsigned e);
    int r = 1;
    for (int unsigned i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  localparam int LEVELS = calc_levels(FAN_IN, RADIX);
  localparam int LANES  = ipow(RADIX, LEVELS);

  // Lane bundle l feeds the nodes of level l; bundle LEVELS is the tree output.
  logic [LANES*FLIT_W-1:0] lane_d [LEVELS+1];
  logic [LANES-1:0]        lane_v [LEVELS+1];
  logic [LANES-1:0]        lane_a [LEVELS+1];

  // Padding lanes FAN_IN..LANES-1 are zero-extended to valid=0, so they never win a grant.
  assign lane_d[0] = (LANES*FLIT_W)'(in);
  assign lane_v[0] = LANES'(in_valid);
  assign in_avail  = lane_a[0][FAN_IN-1:0];

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NC = ipow(RADIX, LEVELS - 1 - l);
    for (genvar n = 0; n < NC; n++) begin : g_node
      radix_reduction_node #(
        .RADIX(RADIX), .FLIT_W(FLIT_W), .HEAD_BIT(HEAD_BIT), .TAIL_BIT(TAIL_BIT)
      ) u_node (
        .clk      (clk),
        .rst      (rst),
        .in_data  (lane_d[l][n*RADIX*FLIT_W +: RADIX*FLIT_W]),
        .in_valid (lane_v[l][n*RADIX +: RADIX]),
        .in_avail (lane_a[l][n*RADIX +: RADIX]),
        .out_data (lane_d[l+1][n*FLIT_W +: FLIT_W]),
        .out_valid(lane_v[l+1][n]),
        .out_avail(lane_a[l+1][n])
      );
    end
    if (NC < LANES) begin : g_tie
      assign lane_d[l+1][LANES*FLIT_W-1:NC*FLIT_W] = '0;
      assign lane_v[l+1][LANES-1:NC]               = '0;
      if (l + 1 < LEVELS) begin : g_tie_a
        assign lane_a[l+1][LANES-1:NC] = '0;
      end else begin : g_tie_top
        assign lane_a[l+1][LANES-1:1] = '0;
      end
    end
  end

  assign lane_a[LEVELS][0] = out_avail;
  assign out               = lane_d[LEVELS][FLIT_W-1:0];
  assign out_valid         = lane_v[LEVELS][0];
endmodule

// File: tb/tb_radix_reduction_tree.sv
// Bench for radix_reduction_tree: 54:1 radix-3 tree (A) and padded 10:1 radix-4 tree (B) against a per-channel scoreboard.
module tb_radix_reduction_tree;
  localparam int FW = 32;
  localparam int FA = 54, RA = 3, LA = 4;
  localparam int FB = 10, RB = 4, LB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [FW*FA-1:0] a_in;
  logic [FA-1:0]    a_in_valid, a_in_avail;
  logic [FW-1:0]    a_out;
  logic             a_out_valid, a_out_avail;
  logic [FW*FB-1:0] b_in;
  logic [FB-1:0]    b_in_valid, b_in_avail;
  logic [FW-1:0]    b_out;
  logic             b_out_valid, b_out_avail;

  radix_reduction_tree #(.FAN_IN(FA), .RADIX(RA), .FLIT_W(FW), .HEAD_BIT(31), .TAIL_BIT(30)) u_dut_a (
    .clk(clk), .rst(rst), .in(a_in), .in_valid(a_in_valid), .in_avail(a_in_avail),
    .out(a_out), .out_valid(a_out_valid), .out_avail(a_out_avail));

  radix_reduction_tree #(.FAN_IN(FB), .RADIX(RB), .FLIT_W(FW), .HEAD_BIT(31), .TAIL_BIT(30)) u_dut_b (
    .clk(clk), .rst(rst), .in(b_in), .in_valid(b_in_valid), .in_avail(b_in_avail),
    .out(b_out), .out_valid(b_out_valid), .out_avail(b_out_avail));

  // src: flits waiting to be offered; sb: flits accepted by the tree, in per-channel order.
  logic [FW-1:0] src_a [FA][$];
  logic [FW-1:0] sb_a  [FA][$];
  logic [FW-1:0] src_b [FB][$];
  logic [FW-1:0] sb_b  [FB][$];
  int            log_cyc[$];
  logic [FW-1:0] log_flit[$];
  int            n_checks = 0, n_fail = 0, cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mkf(bit h, bit t, int seq, int id);
    return {h, t, 6'd0, 8'($urandom), 8'(seq), 8'(id)};
  endfunction

  function automatic int pending();
    int s = 0;
    for (int c = 0; c < FA; c++) s += src_a[c].size() + sb_a[c].size();
    for (int c = 0; c < FB; c++) s += src_b[c].size() + sb_b[c].size();
    return s;
  endfunction

  task automatic drive();
    for (int c = 0; c < FA; c++) begin
      a_in_valid[c] = (src_a[c].size() != 0);
      a_in[c*FW +: FW] = '0;
      if (src_a[c].size() != 0) a_in[c*FW +: FW] = src_a[c][0];
    end
    for (int c = 0; c < FB; c++) begin
      b_in_valid[c] = (src_b[c].size() != 0);
      b_in[c*FW +: FW] = '0;
      if (src_b[c].size() != 0) b_in[c*FW +: FW] = src_b[c][0];
    end
  endtask

  task automatic score_a(input logic [FW-1:0] f);
    int ch;
    ch = int'(f[7:0]);
    check("a_out_id_range", 64'(ch < FA), 64'd1);
    if (ch < FA) begin
      check("a_out_not_spurious", 64'(sb_a[ch].size() != 0), 64'd1);
      if (sb_a[ch].size() != 0) begin
        check("a_out_flit", 64'(f), 64'(sb_a[ch][0]));
        void'(sb_a[ch].pop_front());
      end
    end
    log_cyc.push_back(cyc);
    log_flit.push_back(f);
  endtask

  task automatic score_b(input logic [FW-1:0] f);
    int ch;
    ch = int'(f[7:0]);
    check("b_out_id_range", 64'(ch < FB), 64'd1);
    if (ch < FB) begin
      check("b_out_not_spurious", 64'(sb_b[ch].size() != 0), 64'd1);
      if (sb_b[ch].size() != 0) begin
        check("b_out_flit", 64'(f), 64'(sb_b[ch][0]));
        void'(sb_b[ch].pop_front());
      end
    end
    log_cyc.push_back(cyc);
    log_flit.push_back(f);
  endtask

  // One clock: sample handshakes at negedge, commit them to the model just after posedge.
  task automatic step();
    logic [FA-1:0] av, vv;
    logic [FB-1:0] bav, bvv;
    logic          ov, oa, bov, boa;
    logic [FW-1:0] od, bod;
    drive();
    @(negedge clk);
    av = a_in_avail; vv = a_in_valid; ov = a_out_valid; oa = a_out_avail; od = a_out;
    bav = b_in_avail; bvv = b_in_valid; bov = b_out_valid; boa = b_out_avail; bod = b_out;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < FA; c++) if (vv[c] && av[c]) sb_a[c].push_back(src_a[c].pop_front());
    for (int c = 0; c < FB; c++) if (bvv[c] && bav[c]) sb_b[c].push_back(src_b[c].pop_front());
    if (ov && oa) score_a(od);
    if (bov && boa) score_b(bod);
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(pending()), 64'd0);
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_flit.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int total, first0, last0, n0;
    logic [FW-1:0] f, frz;
    rst = 1'b0;
    a_in = '0; a_in_valid = '0; a_out_avail = 1'b1;
    b_in = '0; b_in_valid = '0; b_out_avail = 1'b1;

    // Reset with every input offering a flit; nothing may be accepted or emitted.
    for (int c = 0; c < FA; c++) src_a[c].push_back(mkf(1'b1, 1'b1, 0, c));
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_out_valid", 64'(a_out_valid), 64'd0);
      check("rst_in_avail", 64'(a_in_avail), 64'd0);
      check("rst_out", 64'(a_out), 64'd0);
      check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    end
    rst = 1'b1;
    cyc = 0;
    clear_log();
    for (int k = 1; k <= LA; k++) begin
      step();
      check($sformatf("first_valid_c%0d", k), 64'(a_out_valid), 64'(k == LA));
    end

    // Fairness: 54 single flits out on 54 consecutive cycles.
    drain("t2_drain", 200);
    check("t2_count", 64'(log_cyc.size()), 64'd54);
    if (log_cyc.size() != 0) begin
      check("t2_first_cycle", 64'(log_cyc[0]), 64'(LA + 1));
      check("t2_span", 64'(log_cyc[log_cyc.size()-1] - log_cyc[0]), 64'd53);
    end

    // Backpressure: 10-cycle stall while all channels stream.
    clear_log();
    for (int c = 0; c < FA; c++)
      for (int s = 0; s < 3; s++) src_a[c].push_back(mkf(1'b1, 1'b1, s, c));
    repeat (30) step();
    a_out_avail = 1'b0;
    frz = a_out;
    check("t3_stall_valid", 64'(a_out_valid), 64'd1);
    f = '0;
    if (int'(frz[7:0]) < FA && sb_a[frz[7:0]].size() != 0) f = sb_a[frz[7:0]][0];
    check("t3_stall_head", 64'(a_out), 64'(f));
    for (int k = 0; k < 10; k++) begin
      step();
      check("t3_hold_valid", 64'(a_out_valid), 64'd1);
      check("t3_hold_data", 64'(a_out), 64'(f));
    end
    a_out_avail = 1'b1;
    drain("t3_drain", 400);
    check("t3_count", 64'(log_cyc.size()), 64'(FA * 3));

    // Random load with random downstream readiness.
    clear_log();
    total = 0;
    for (int c = 0; c < FA; c++) begin
      int n;
      n = int'($urandom_range(0, 3));
      for (int s = 0; s < n; s++) src_a[c].push_back(mkf(1'b1, 1'b1, s, c));
      total += n;
    end
    for (int k = 0; k < 3000 && pending() != 0; k++) begin
      a_out_avail = ($urandom_range(0, 3) != 0);
      step();
    end
    a_out_avail = 1'b1;
    drain("rnd_drain", 100);
    check("rnd_count", 64'(log_cyc.size()), 64'(total));

    // Packet lock: ch0 4-flit packet against ch1 single flits.
    clear_log();
    src_a[0].push_back(mkf(1'b1, 1'b0, 0, 0));
    src_a[0].push_back(mkf(1'b0, 1'b0, 1, 0));
    src_a[0].push_back(mkf(1'b0, 1'b0, 2, 0));
    src_a[0].push_back(mkf(1'b0, 1'b1, 3, 0));
    for (int s = 0; s < 4; s++) src_a[1].push_back(mkf(1'b1, 1'b1, s, 1));
    drain("t4_drain", 100);
    first0 = -1; last0 = -1; n0 = 0;
    for (int i = 0; i < log_flit.size(); i++) begin
      if (log_flit[i][7:0] == 8'd0) begin
        if (first0 < 0) first0 = log_cyc[i];
        last0 = log_cyc[i];
        n0++;
      end
    end
    check("t4_ch0_count", 64'(n0), 64'd4);
`ifdef PKT_LOCK_EN
    check("t4_ch0_contiguous", 64'(last0 - first0), 64'd3);
`else
    check("t4_ch0_interleaved", 64'(last0 - first0 > 3), 64'd1);
`endif

    // Reset mid-packet: head passes, a body flit is buffered, then reset.
    clear_log();
    src_a[0].push_back(mkf(1'b1, 1'b0, 0, 0));
    repeat (8) step();
    check("t6_head_out", 64'(log_cyc.size()), 64'd1);
    a_out_avail = 1'b0;
    src_a[0].push_back(mkf(1'b0, 1'b0, 1, 0));
    repeat (6) step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("t6_rst_out_valid", 64'(a_out_valid), 64'd0);
      check("t6_rst_in_avail", 64'(a_in_avail), 64'd0);
    end
    for (int c = 0; c < FA; c++) begin
      src_a[c].delete();
      sb_a[c].delete();
    end
    rst = 1'b1;
    a_out_avail = 1'b1;
    clear_log();
    check("t6_release_valid", 64'(a_out_valid), 64'd0);
    repeat (3) step();
    check("t6_discarded", 64'(a_out_valid), 64'd0);
    f = mkf(1'b1, 1'b1, 0, 1);
    src_a[1].push_back(f);
    repeat (LA) step();
    check("t6_ch1_valid", 64'(a_out_valid), 64'd1);
    check("t6_ch1_data", 64'(a_out), 64'(f));
    drain("t6_drain", 20);
    check("t6_count", 64'(log_cyc.size()), 64'd1);

    // Padded tree: 10 channels on a 16-lane radix-4 tree.
    clear_log();
    f = mkf(1'b1, 1'b1, 0, 9);
    src_b[9].push_back(f);
    step();
    check("t5_lat_c1", 64'(b_out_valid), 64'd0);
    step();
    check("t5_lat_c2", 64'(b_out_valid), 64'd1);
    check("t5_lat_data", 64'(b_out), 64'(f));
    drain("t5_lat_drain", 20);
    clear_log();
    for (int c = 0; c < FB; c++)
      for (int s = 0; s < 2; s++) src_b[c].push_back(mkf(1'b1, 1'b1, s, c));
    for (int k = 0; k < 500 && pending() != 0; k++) begin
      b_out_avail = ($urandom_range(0, 3) != 0);
      step();
    end
    b_out_avail = 1'b1;
    drain("t5_drain", 50);
    check("t5_count", 64'(log_cyc.size()), 64'(FB * 2));
    repeat (5) step();
    check("t5_idle", 64'(b_out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
